// File: rtl/box_filter_sched.sv
// Moving-average engine time-shared between N_CH sample streams by a round-robin arbiter,
// with a per-channel clear sequencer that zeroes one window an entry per cycle.
module box_filter_sched #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned FILTER_SIZE = 4,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            req_valid,
    input  logic [N_CH*DATA_W-1:0]     req_data,
    output logic [N_CH-1:0]            req_ready,
    output logic                       out_valid,
    output logic [$clog2(N_CH)-1:0]    out_ch,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    input  logic                       clr_valid,
    input  logic [$clog2(N_CH)-1:0]    clr_ch,
    output logic                       clr_ready,
    output logic                       clr_done
);

    localparam int unsigned CH_W    = $clog2(N_CH);
    localparam int unsigned LOG2_FS = $clog2(FILTER_SIZE);
    localparam int unsigned SUM_W   = DATA_W + LOG2_FS;
    localparam logic [LOG2_FS-1:0] LAST_IDX = LOG2_FS'(FILTER_SIZE - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LOG2_FS-1:0]  clr_cnt_q, clr_cnt_d;
    logic [CH_W-1:0]     clr_ch_q, clr_ch_d;
    logic                clr_done_q, clr_done_d;

    logic [DATA_W-1:0]   hist_q [N_CH][FILTER_SIZE];
    logic [SUM_W-1:0]    sum_q  [N_CH];
    logic [LOG2_FS-1:0]  wp_q   [N_CH];
    logic [CH_W-1:0]     rr_q;
    logic                out_valid_q;
    logic [CH_W-1:0]     out_ch_q;
    logic [DATA_W-1:0]   out_data_q;

    logic                grant_found;
    logic [CH_W-1:0]     grant_ch;
    int unsigned         idx;
    logic                slot_free;
    logic                accept;
    logic [DATA_W-1:0]   x_sel;
    logic [DATA_W-1:0]   old_sel;
    logic [SUM_W-1:0]    new_sum;

    // Round-robin search: first valid channel at or after rr_q, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!grant_found && req_valid[CH_W'(idx)]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(idx);
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign accept    = grant_found && (state_q == RUN) && !clr_valid && slot_free;
    assign req_ready = accept ? (N_CH'(1) << grant_ch) : '0;
    assign clr_ready = (state_q == RUN);

    assign x_sel   = req_data[32'(grant_ch) * DATA_W +: DATA_W];
    assign old_sel = hist_q[grant_ch][wp_q[grant_ch]];
    assign new_sum = sum_q[grant_ch] + SUM_W'(x_sel) - SUM_W'(old_sel);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_ch_d   = clr_ch_q;
        clr_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (clr_valid) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    clr_ch_d  = clr_ch;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_IDX) state_d = RUN;
                else clr_cnt_d = LOG2_FS'(clr_cnt_q + 1'b1);
            end
            default: state_d = RUN;
        endcase
        // Registered pulse lands in the final CLEAR cycle.
        clr_done_d = (state_d == CLEAR) && (clr_cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            clr_cnt_q  <= '0;
            clr_ch_q   <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_ch_q   <= clr_ch_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                for (int unsigned e = 0; e < FILTER_SIZE; e++) hist_q[c][e] <= '0;
                sum_q[c] <= '0;
                wp_q[c]  <= '0;
            end
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                hist_q[grant_ch][wp_q[grant_ch]] <= x_sel;
                wp_q[grant_ch]  <= LOG2_FS'(wp_q[grant_ch] + 1'b1);
                sum_q[grant_ch] <= new_sum;
                rr_q        <= (32'(grant_ch) == N_CH - 1) ? '0 : CH_W'(grant_ch + 1'b1);
                out_valid_q <= 1'b1;
                out_ch_q    <= grant_ch;
                out_data_q  <= DATA_W'(new_sum >> LOG2_FS);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Accepts are blocked in CLEAR, so these writes never collide with a sample update.
            if (state_q == CLEAR) begin
                hist_q[clr_ch_q][clr_cnt_q] <= '0;
                if (clr_cnt_q == '0) begin
                    sum_q[clr_ch_q] <= '0;
                    wp_q[clr_ch_q]  <= '0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign clr_done  = clr_done_q;

endmodule

// File: doc/box_filter_sched.md
Name: box_filter_sched

Overview:
- Shares one moving-average (box filter) engine between N_CH sample streams.
- Each channel keeps its own FILTER_SIZE-deep history and running sum in local flops.
- A round-robin arbiter picks one channel per cycle. The selected channel's sample updates that channel's window, and the new average is returned tagged with the channel ID.
- A per-channel clear sequencer zeroes one channel's history without disturbing the other channels.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- FILTER_SIZE, 4, window depth per channel; must be a power of 2 (2..64).
- DATA_W, 32, sample and average width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_CH  per-channel sample valid.
- req_data  in  N_CH*DATA_W  per-channel sample; channel i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_CH  per-channel accept; one-hot or all zero.
- out_valid  out  1  average result valid.
- out_ch  out  $clog2(N_CH)  channel the result belongs to.
- out_data  out  DATA_W  window average.
- out_ready  in  1  downstream accept.
- clr_valid  in  1  request to clear channel clr_ch.
- clr_ch  in  $clog2(N_CH)  channel to clear.
- clr_ready  out  1  clear request accepted.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset:
  - All history entries, sums and write pointers go to 0.
  - RR pointer goes to 0 and state goes to RUN.
  - out_valid, out_ch, out_data, clr_done and req_ready all reset to 0.
  - Reset mid-clear or with a pending output discards everything; nothing is emitted.
- States: RUN and CLEAR.
  - RUN -> CLEAR on clr_valid && clr_ready.
  - CLEAR -> RUN after FILTER_SIZE cycles.
- clr_ready = (state == RUN). A clear request takes priority over samples in the same cycle: while clr_valid is high in RUN, req_ready is all 0.
- Output slot: a single register. slot_free = !out_valid || out_ready.
- Arbitration (combinational):
  - Among asserted req_valid bits, grant the first at or after rr_ptr, wrapping modulo N_CH.
  - req_ready[g] = 1 only if state == RUN, clr_valid == 0 and slot_free; all other bits are 0.
  - On each accept from channel g, rr_ptr <= (g + 1) mod N_CH.
  - rr_ptr is unchanged when there is no accept.
- Sample update on an accept from channel g with sample x at edge T:
  - old = hist[g][wp[g]].
  - hist[g][wp[g]] <= x.
  - wp[g] <= wp[g] + 1, wrapping at FILTER_SIZE.
  - sum[g] <= sum[g] + x - old.
  - Result registered at edge T: out_valid = 1, out_ch = g, out_data = (sum[g] + x - old) >> log2(FILTER_SIZE), truncating.
  - The result is visible in the cycle after the accept (latency 1). Accepts can continue every cycle while out_ready stays high.
- Sum width is DATA_W + log2(FILTER_SIZE). The sum never overflows and out_data always fits in DATA_W.
- Window semantics: history starts at zero, so the first FILTER_SIZE outputs average against zeros. For example, after k < FILTER_SIZE samples the result is (sum of k samples) / FILTER_SIZE.
- Output hold: while out_valid && !out_ready, out_ch and out_data hold and no new sample is accepted.
- Output clear: out_valid clears on out_ready when there is no accept in the same cycle.
- CLEAR sequence for channel c:
  - One history entry is zeroed per cycle, indices 0..FILTER_SIZE-1.
  - sum[c] and wp[c] are zeroed in the first CLEAR cycle.
  - clr_done pulses in the last CLEAR cycle; state is RUN on the next cycle.
  - All req_ready bits are 0 during CLEAR.
  - A pending output still drains during CLEAR.
  - Other channels' state is untouched.
- No timeout exists: a request held valid is eventually granted within N_CH accept slots.

Test Plan:
- Ramp, single channel (N_CH=2, FILTER_SIZE=4, out_ready=1): ch0 pushes 4, 8, 12, 16 -> out_data 1, 3, 6, 10 with out_ch=0, each one cycle after its accept.
- Wrap-around: ch0 pushes 1..6 -> outputs 0, 0, 1, 2, 3, 4. The last output equals (3+4+5+6)/4 = 4, confirming the oldest samples drop out.
- Round-robin fairness: all channels hold req_valid=1 for 8 cycles -> grant order 0, 1, 0, 1, ... with no channel starved. Channel windows stay independent: ch0 gets 4s and ch1 gets 8s -> final averages 4 and 8.
- Backpressure: drop out_ready for 3 cycles while out_valid=1 -> out_data and out_ch stable, req_ready all 0, no sample lost or duplicated. Releasing out_ready resumes accepts the same cycle.
- Clear:
  - Setup: ch0 holds four samples of 100 (average 100) and ch1 holds four samples of 20.
  - Clear ch0: clr_ready=1, clr_done pulses FILTER_SIZE cycles later and req_ready stays 0 throughout.
  - Then ch0 pushes 40 -> 10, and ch1 pushes 20 -> 20.
- Extremes and reset: four samples of 0xFFFFFFFF -> 0xFFFFFFFF with no overflow.
  - Assert rst during CLEAR with out_valid=1 -> next cycle out_valid=0, clr_done=0, state RUN.
  - Next pushed sample 8 -> 2.
